rti_core: RTL and testbench

//  Real-time input core: inverse of the timed-output path. Timestamps input events with the

---
 rtl/rti_pkg.sv | 11 +
 rtl/rti_sync_fifo.sv | 78 +++++++
 rtl/rti_core.sv | 96 +++++++++
 tb/tb_rti_core.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/rti_pkg.sv
// Shared widths and the packed {timestamp, payload} word stored by the real-time input core.
package rti_pkg;
  localparam int TS_WIDTH   = 64;
  localparam int DATA_WIDTH = 64;
  localparam int WORD_WIDTH = TS_WIDTH + DATA_WIDTH;

  typedef struct packed {
    logic [TS_WIDTH-1:0]   ts;
    logic [DATA_WIDTH-1:0] data;
  } rti_word_t;
endpackage

// File: rtl/rti_sync_fifo.sv
// Single-clock FIFO with registered read port, occupancy count, programmable full and empty.
// The caller guarantees no push at true capacity (prog_full is always below DEPTH).
module rti_sync_fifo #(
  parameter int WIDTH            = 128,
  parameter int DEPTH            = 1024,
  parameter int PROG_FULL_THRESH = 1000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush_i,
  input  logic                     wr_en_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     rd_en_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     prog_full_o,
  output logic                     empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] rd_data_q;
  logic             push, pop;

  // Flags come from the registered count, so they describe the start of the cycle.
  assign empty_o     = (count_q == '0);
  assign prog_full_o = (count_q >= CW'(PROG_FULL_THRESH));
  assign push        = wr_en_i && !flush_i;
  assign pop         = rd_en_i && !empty_o && !flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= wr_data_i;
  end

  // Read register holds the last popped word; it survives flush but not reset.
  always_ff @(posedge clk) begin
    if (reset)    rd_data_q <= '0;
    else if (pop) rd_data_q <= mem[rd_ptr_q];
  end

  assign rd_data_o = rd_data_q;
  assign count_o   = count_q;
endmodule

// File: rtl/rti_core.sv
// Real-time input core: timestamps input events with the global counter, queues the
// {timestamp, data} words for the host, and reports overflow (with the dropped word) and underflow.
module rti_core
  import rti_pkg::*;
#(
  parameter int TS_WIDTH         = rti_pkg::TS_WIDTH,
  parameter int DATA_WIDTH       = rti_pkg::DATA_WIDTH,
  parameter int FIFO_DEPTH       = 1024,
  parameter int PROG_FULL_THRESH = 1000
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           auto_start,
  input  logic                           flush,
  input  logic [TS_WIDTH-1:0]            counter,
  input  logic                           event_valid,
  input  logic [DATA_WIDTH-1:0]          event_data,
  input  logic                           read,
  output logic [TS_WIDTH+DATA_WIDTH-1:0] rti_out,
  output logic                           rti_out_valid,
  output logic                           overflow_error,
  output logic [TS_WIDTH+DATA_WIDTH-1:0] overflow_error_data,
  output logic                           underflow_error,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_count
);
  rti_word_t cap_word_q, cap_word_d;
  logic      cap_vld_q, cap_vld_d;
  logic      push, drop, pop, under;
  logic      rti_out_valid_q, overflow_error_q, underflow_error_q;
  rti_word_t ovf_data_q, ovf_data_d;

  // Capture stage: the timestamp is the counter value at the strobe edge.
  always_comb begin
    cap_vld_d  = event_valid && auto_start && !flush;
    cap_word_d = cap_word_q;
    if (cap_vld_d) begin
      cap_word_d.ts   = counter;
      cap_word_d.data = event_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cap_vld_q <= 1'b0;
    else       cap_vld_q <= cap_vld_d;
    cap_word_q <= cap_word_d;
  end

  // Write/drop and read/underflow decisions against start-of-cycle full/empty.
  assign push  = cap_vld_q && !full && !flush;
  assign drop  = cap_vld_q &&  full && !flush;
  assign pop   = read && !empty && !flush;
  assign under = read &&  empty && !flush;

  always_comb begin
    ovf_data_d = ovf_data_q;
    if (drop) ovf_data_d = cap_word_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rti_out_valid_q   <= 1'b0;
      overflow_error_q  <= 1'b0;
      underflow_error_q <= 1'b0;
      ovf_data_q        <= '0;
    end else begin
      rti_out_valid_q   <= pop;
      overflow_error_q  <= drop;
      underflow_error_q <= under;
      ovf_data_q        <= ovf_data_d;
    end
  end

  rti_sync_fifo #(
    .WIDTH            ($bits(rti_word_t)),
    .DEPTH            (FIFO_DEPTH),
    .PROG_FULL_THRESH (PROG_FULL_THRESH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .flush_i     (flush),
    .wr_en_i     (push),
    .wr_data_i   (cap_word_q),
    .rd_en_i     (pop),
    .rd_data_o   (rti_out),
    .count_o     (fifo_count),
    .prog_full_o (full),
    .empty_o     (empty)
  );

  assign rti_out_valid       = rti_out_valid_q;
  assign overflow_error      = overflow_error_q;
  assign overflow_error_data = ovf_data_q;
  assign underflow_error     = underflow_error_q;
endmodule

// File: tb/tb_rti_core.sv
// Bench for rti_core: queue-based reference model checked every cycle, directed scenarios
// with literal expectations, then randomized traffic including fill-to-overflow, flush and reset.
module tb_rti_core;
  localparam int DEPTH  = 1024;
  localparam int THRESH = 1000;

  logic         clk = 1'b0;
  logic         reset = 1'b1, auto_start = 1'b1, flush = 1'b0, event_valid = 1'b0, read = 1'b0;
  logic [63:0]  counter = '0, event_data = '0;
  logic [127:0] rti_out, overflow_error_data;
  logic         rti_out_valid, overflow_error, underflow_error, full, empty;
  logic [10:0]  fifo_count;

  always #5 clk = ~clk;

  rti_core #(
    .TS_WIDTH(64), .DATA_WIDTH(64), .FIFO_DEPTH(DEPTH), .PROG_FULL_THRESH(THRESH)
  ) dut (
    .clk(clk), .reset(reset), .auto_start(auto_start), .flush(flush), .counter(counter),
    .event_valid(event_valid), .event_data(event_data), .read(read),
    .rti_out(rti_out), .rti_out_valid(rti_out_valid), .overflow_error(overflow_error),
    .overflow_error_data(overflow_error_data), .underflow_error(underflow_error),
    .full(full), .empty(empty), .fifo_count(fifo_count)
  );

  // Reference model: a queue of stored words plus the one-deep capture stage.
  logic [127:0] mq[$];
  bit           m_cap_vld = 0;
  logic [127:0] m_cap_word = '0, m_rti_out = '0, m_ovf_data = '0;
  bit           m_rv = 0, m_ovf = 0, m_unf = 0, model_ok = 0;

  always @(posedge clk) begin : model
    int occ;
    bit was_full;
    occ      = mq.size();
    was_full = (occ >= THRESH);
    m_rv = 0; m_ovf = 0; m_unf = 0;
    if (reset) begin
      mq.delete();
      m_cap_vld = 0; m_rti_out = '0; m_ovf_data = '0; model_ok = 1;
    end else if (flush) begin
      mq.delete();
      m_cap_vld = 0;
    end else begin
      if (read) begin
        if (occ > 0) begin m_rti_out = mq.pop_front(); m_rv = 1; end
        else m_unf = 1;
      end
      if (m_cap_vld) begin
        if (!was_full) mq.push_back(m_cap_word);
        else begin m_ovf = 1; m_ovf_data = m_cap_word; end
      end
      m_cap_vld  = event_valid && auto_start;
      m_cap_word = {counter, event_data};
    end
  end

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin : compare
    if (model_ok) begin
      chk("rti_out",             rti_out,                   m_rti_out);
      chk("rti_out_valid",       128'(rti_out_valid),       128'(m_rv));
      chk("overflow_error",      128'(overflow_error),      128'(m_ovf));
      chk("overflow_error_data", overflow_error_data,       m_ovf_data);
      chk("underflow_error",     128'(underflow_error),     128'(m_unf));
      chk("fifo_count",          128'(fifo_count),          128'(mq.size()));
      chk("empty",               128'(empty),               128'(mq.size() == 0));
      chk("full",                128'(full),                128'(mq.size() >= THRESH));
    end
  end

  logic [63:0] next_cnt = 64'd1;

  task automatic drive(input bit ev, input logic [63:0] d, input bit rd, input bit fl, input bit rs);
    @(negedge clk);
    counter     = next_cnt;
    next_cnt    = next_cnt + 64'd1;
    event_valid = ev;
    event_data  = d;
    read        = rd;
    flush       = fl;
    reset       = rs;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(0, '0, 0, 0, 0);
  endtask

  initial begin : stim
    int pe, pr;
    bit ev, rd, fl, rs;

    // Reset state
    drive(0, '0, 0, 0, 1);
    chk("rst_rti_out", rti_out, '0);
    chk("rst_empty", 128'(empty), 128'd1);
    chk("rst_count", 128'(fifo_count), 128'd0);
    chk("rst_pulses", 128'({rti_out_valid, overflow_error, underflow_error, full}), 128'd0);
    drive(0, '0, 0, 0, 0);

    // Single event at counter=100, then read it back
    next_cnt = 64'd100;
    drive(1, 64'hA5, 0, 0, 0);
    drive(0, '0, 0, 0, 0);
    drive(0, '0, 1, 0, 0);
    chk("t1_empty_after_2", 128'(empty), 128'd0);
    drive(0, '0, 0, 0, 0);
    chk("t1_rti_out", rti_out, {64'd100, 64'hA5});
    chk("t1_valid", 128'(rti_out_valid), 128'd1);
    chk("t1_model_pin", m_rti_out, {64'd100, 64'hA5});
    drive(0, '0, 0, 0, 0);
    chk("t1_valid_pulse", 128'(rti_out_valid), 128'd0);

    // Capture disabled
    auto_start = 1'b0;
    for (int i = 0; i < 5; i++) drive(1, 64'(i), 0, 0, 0);
    idle(2);
    chk("t2_empty", 128'(empty), 128'd1);
    chk("t2_count", 128'(fifo_count), 128'd0);
    auto_start = 1'b1;

    // Fill to threshold, then overflow
    for (int i = 0; i < THRESH; i++) drive(1, 64'(i), 0, 0, 0);
    idle(2);
    chk("t3_count_fill", 128'(fifo_count), 128'd1000);
    chk("t3_full", 128'(full), 128'd1);
    chk("t3_model_pin", 128'(mq.size()), 128'd1000);
    next_cnt = 64'd2000;
    drive(1, 64'hDEAD, 0, 0, 0);
    idle(2);
    chk("t3_ovf", 128'(overflow_error), 128'd1);
    chk("t3_ovf_ts", 128'(overflow_error_data[127:64]), 128'd2000);
    chk("t3_count_held", 128'(fifo_count), 128'd1000);
    idle(1);
    chk("t3_ovf_pulse", 128'(overflow_error), 128'd0);

    // Underflow
    drive(0, '0, 0, 1, 0);
    drive(0, '0, 1, 0, 0);
    idle(1);
    chk("t4_unf", 128'(underflow_error), 128'd1);
    chk("t4_no_valid", 128'(rti_out_valid), 128'd0);
    chk("t4_rti_out_kept", rti_out, {64'd100, 64'hA5});

    // Simultaneous read and write keep occupancy; FIFO order
    next_cnt = 64'd500;
    for (int i = 0; i < 10; i++) drive(1, 64'h10 + 64'(i), 0, 0, 0);
    idle(2);
    chk("t5_count10", 128'(fifo_count), 128'd10);
    drive(1, 64'hEE, 0, 0, 0);
    drive(0, '0, 1, 0, 0);
    idle(1);
    chk("t5_count_same", 128'(fifo_count), 128'd10);
    chk("t5_oldest", rti_out, {64'd500, 64'h10});
    chk("t5_valid", 128'(rti_out_valid), 128'd1);

    // Flush with coincident event and read
    drive(0, '0, 0, 1, 0);
    for (int i = 0; i < 3; i++) drive(1, 64'h30 + 64'(i), 0, 0, 0);
    idle(2);
    chk("t6_count3", 128'(fifo_count), 128'd3);
    drive(1, 64'h99, 1, 1, 0);
    idle(1);
    chk("t6_empty", 128'(empty), 128'd1);
    chk("t6_count0", 128'(fifo_count), 128'd0);
    chk("t6_no_valid", 128'(rti_out_valid), 128'd0);
    chk("t6_no_unf", 128'(underflow_error), 128'd0);
    idle(1);
    chk("t6_evt_dropped", 128'(empty), 128'd1);
    next_cnt = 64'd777;
    drive(1, 64'h77, 0, 0, 0);
    idle(2);
    drive(0, '0, 1, 0, 0);
    idle(1);
    chk("t6_readback", rti_out, {64'd777, 64'h77});

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      if (i < 1600)      begin pe = 95; pr = 15; end
      else if (i < 2400) begin pe = 40; pr = 90; end
      else               begin pe = 60; pr = 60; end
      ev = ($urandom_range(0, 99) < pe);
      rd = ($urandom_range(0, 99) < pr);
      fl = (i >= 1600) && ($urandom_range(0, 299) == 0);
      rs = (i == 3000);
      if (i >= 1600 && $urandom_range(0, 199) == 0) auto_start = ~auto_start;
      if ($urandom_range(0, 99) == 0) next_cnt = {$urandom, $urandom};
      drive(ev, {$urandom, $urandom}, rd, fl, rs);
    end
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
